// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and a valid/ready byte output.
// Flags framing errors on a low stop bit and overruns when a byte lands on a full holding register.
module uart_rx #(
  parameter int CLOCKS_PER_BIT = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ser_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, WAIT_HIGH = 3'd4;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d, data_q, data_d;
  logic          valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic          tick, deliver, load;
  assign rx_s = sync_q[1];
  assign tick = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q - 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        cnt_d   = HALF_M1;
      end
      START: if (tick) begin
        state_d = rx_s ? IDLE : DATA;
        cnt_d   = FULL_M1;
        idx_d   = '0;
      end
      DATA: if (tick) begin
        sh_d    = {rx_s, sh_q[7:1]};
        idx_d   = idx_q + 1'b1;
        cnt_d   = FULL_M1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      // Leaving at the mid-stop sample lets the next start edge resynchronise us.
      STOP: if (tick) begin
        state_d = rx_s ? IDLE : WAIT_HIGH;
        deliver = rx_s;
        ferr_d  = !rx_s;
      end
      WAIT_HIGH: state_d = rx_s ? IDLE : WAIT_HIGH;
      default: state_d = IDLE;
    endcase
    load    = deliver && (!valid_q || i_ready);
    ovr_d   = deliver && valid_q && !i_ready;
    valid_d = load || (valid_q && !i_ready);
    data_d  = load ? sh_q : data_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], ser_rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = state_q != IDLE;
endmodule
